ss_rom_addr_seq: RTL and testbench



---
 rtl/ss_rom_addr_seq_pkg.sv | 12 +
 rtl/ss_rom_addr_seq_step.sv | 22 ++
 rtl/ss_rom_addr_seq.sv | 128 ++++++++++++
 tb/tb_ss_rom_addr_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ss_rom_addr_seq_pkg.sv
// Shared types and default widths for the sample-ROM address sequencer.
package ss_rom_pkg;

    localparam int ADDR_ROM_DEF = 16;
    localparam int STEP_W_DEF   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/ss_rom_addr_seq_step.sv
// Next-address adder with carry-extended end-of-range compare; a step of 0 advances by 1.
module ss_rom_addr_step #(
    parameter int ADDR_ROM = 16,
    parameter int STEP_W   = 4
) (
    input  logic [ADDR_ROM-1:0] addr_i,
    input  logic [ADDR_ROM-1:0] last_i,
    input  logic [STEP_W-1:0]   step_i,
    output logic [ADDR_ROM-1:0] nxt_o,
    output logic                ovf_o
);

    logic [STEP_W-1:0] step_eff;
    logic [ADDR_ROM:0] sum;

    assign step_eff = (step_i == '0) ? STEP_W'(1) : step_i;
    // The extra carry bit stops an address near the top of the map from wrapping to a small value.
    assign sum   = {1'b0, addr_i} + {{(ADDR_ROM + 1 - STEP_W){1'b0}}, step_eff};
    assign ovf_o = sum > {1'b0, last_i};
    assign nxt_o = sum[ADDR_ROM-1:0];

endmodule

// File: rtl/ss_rom_addr_seq.sv
// Bounded, strided ROM address generator with valid/ready output and done/wrap pulses.
// Optional SS_ROM_ADDR_SEQ_ERR_EN adds a sticky o_err that rejects starts with base > last.
module ss_rom_addr_seq
    import ss_rom_pkg::*;
#(
    parameter int ADDR_ROM = ADDR_ROM_DEF,
    parameter int STEP_W   = STEP_W_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic [ADDR_ROM-1:0] i_cfg_base,
    input  logic [ADDR_ROM-1:0] i_cfg_last,
    input  logic [STEP_W-1:0]   i_cfg_step,
    input  logic                i_cfg_wrap,
    input  logic                i_ready,
    output logic [ADDR_ROM-1:0] o_rom_addr,
    output logic                o_valid,
    output logic                o_busy,
    output logic                o_done,
`ifdef SS_ROM_ADDR_SEQ_ERR_EN
    output logic                o_err,
`endif
    output logic                o_wrap
);

    typedef struct packed {
        logic [ADDR_ROM-1:0] base;
        logic [ADDR_ROM-1:0] last;
        logic [STEP_W-1:0]   step;
        logic                wrap;
    } cfg_t;

    state_e              state_q;
    cfg_t                cfg_q;
    logic [ADDR_ROM-1:0] addr_q;
    logic                valid_q;
    logic                done_q;
    logic                wrap_q;
    logic [ADDR_ROM-1:0] nxt_addr;
    logic                nxt_ovf;
    logic                xfer;

    ss_rom_addr_step #(
        .ADDR_ROM (ADDR_ROM),
        .STEP_W   (STEP_W)
    ) u_step (
        .addr_i (addr_q),
        .last_i (cfg_q.last),
        .step_i (cfg_q.step),
        .nxt_o  (nxt_addr),
        .ovf_o  (nxt_ovf)
    );

    assign xfer = (state_q == RUN) && valid_q && i_ready;

`ifdef SS_ROM_ADDR_SEQ_ERR_EN
    logic err_q;
    logic cfg_bad;

    assign cfg_bad = i_cfg_base > i_cfg_last;
    assign o_err   = err_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            err_q <= 1'b0;
        end else if (i_start && !i_stop) begin
            err_q <= cfg_bad;
        end
    end
`else
    logic cfg_bad;

    assign cfg_bad = 1'b0;
`endif

    // Priority: stop, then start, then an accepted transfer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cfg_q   <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            wrap_q <= 1'b0;
            if (i_stop) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
            end else if (i_start) begin
                if (cfg_bad) begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end else begin
                    cfg_q.base <= i_cfg_base;
                    cfg_q.last <= i_cfg_last;
                    cfg_q.step <= i_cfg_step;
                    cfg_q.wrap <= i_cfg_wrap;
                    addr_q     <= i_cfg_base;
                    state_q    <= RUN;
                    valid_q    <= 1'b1;
                end
            end else if (xfer) begin
                if (!nxt_ovf) begin
                    addr_q <= nxt_addr;
                end else if (cfg_q.wrap) begin
                    addr_q <= cfg_q.base;
                    wrap_q <= 1'b1;
                end else begin
                    // One-shot end: the last issued address stays on the bus.
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    done_q  <= 1'b1;
                end
            end
        end
    end

    assign o_rom_addr = addr_q;
    assign o_valid    = valid_q;
    assign o_busy     = (state_q == RUN);
    assign o_done     = done_q;
    assign o_wrap     = wrap_q;

endmodule

// File: tb/tb_ss_rom_addr_seq.sv
// Scoreboard bench for ss_rom_addr_seq: expected addresses are queued at start and popped on each transfer.
module tb_ss_rom_addr_seq;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_stop = 1'b0;
    logic [15:0] i_cfg_base = '0;
    logic [15:0] i_cfg_last = '0;
    logic [3:0]  i_cfg_step = '0;
    logic        i_cfg_wrap = 1'b0;
    logic        i_ready = 1'b0;
    logic [15:0] o_rom_addr;
    logic        o_valid;
    logic        o_busy;
    logic        o_done;
    logic        o_wrap;
`ifdef SS_ROM_ADDR_SEQ_ERR_EN
    logic        o_err;
`endif

    typedef struct {
        logic [15:0] addr;
        bit          done;
        bit          wrap;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] model_next;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 i_clk = ~i_clk;

    ss_rom_addr_seq #(
        .ADDR_ROM (16),
        .STEP_W   (4)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_stop     (i_stop),
        .i_cfg_base (i_cfg_base),
        .i_cfg_last (i_cfg_last),
        .i_cfg_step (i_cfg_step),
        .i_cfg_wrap (i_cfg_wrap),
        .i_ready    (i_ready),
        .o_rom_addr (o_rom_addr),
        .o_valid    (o_valid),
        .o_busy     (o_busy),
        .o_done     (o_done),
`ifdef SS_ROM_ADDR_SEQ_ERR_EN
        .o_err      (o_err),
`endif
        .o_wrap     (o_wrap)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference walk of the address stream: push n transfers (or up to the one-shot end).
    function automatic void gen(input logic [15:0] base, input logic [15:0] last,
                                input logic [3:0] step, input bit wrap, input int n);
        logic [15:0] a;
        logic [16:0] nxt;
        logic [16:0] se;
        exp_t        it;
        a  = base;
        se = (step == 4'd0) ? 17'd1 : {13'd0, step};
        for (int i = 0; i < n; i++) begin
            it.addr = a;
            it.done = 1'b0;
            it.wrap = 1'b0;
            nxt = {1'b0, a} + se;
            if (nxt <= {1'b0, last}) begin
                a = nxt[15:0];
            end else if (wrap) begin
                a = base;
                it.wrap = 1'b1;
            end else begin
                it.done = 1'b1;
                exp_q.push_back(it);
                break;
            end
            exp_q.push_back(it);
        end
        model_next = a;
    endfunction

    task automatic start_seq(input logic [15:0] base, input logic [15:0] last,
                             input logic [3:0] step, input bit wrap, input bit rdy);
        i_cfg_base = base;
        i_cfg_last = last;
        i_cfg_step = step;
        i_cfg_wrap = wrap;
        i_ready    = rdy;
        i_start    = 1'b1;
        @(posedge i_clk); #1;
        i_start    = 1'b0;
    endtask

    task automatic stop_seq();
        i_stop = 1'b1;
        @(posedge i_clk); #1;
        i_stop = 1'b0;
    endtask

    // mode 0: ready held high; mode 1: ready pattern 1,0,0 repeating.
    task automatic drain(input int max_cycles, input int mode);
        int   cyc = 0;
        bit   pend_done = 1'b0;
        bit   pend_wrap = 1'b0;
        bit   rdy;
        exp_t it;
        while (exp_q.size() > 0) begin
            if (cyc >= max_cycles) begin
                check("timeout_left", exp_q.size(), 0);
                exp_q.delete();
                break;
            end
            check("done_pulse", o_done, pend_done);
            check("wrap_pulse", o_wrap, pend_wrap);
            check("valid", o_valid, 1);
            check("busy", o_busy, 1);
            rdy = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            i_ready = rdy;
            if (rdy) begin
                it = exp_q.pop_front();
                check("addr", o_rom_addr, it.addr);
                pend_done = it.done;
                pend_wrap = it.wrap;
            end else begin
                check("addr_hold", o_rom_addr, exp_q[0].addr);
                pend_done = 1'b0;
                pend_wrap = 1'b0;
            end
            @(posedge i_clk); #1;
            cyc++;
        end
        check("done_pulse_end", o_done, pend_done);
        check("wrap_pulse_end", o_wrap, pend_wrap);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_addr", o_rom_addr, 0);
        check("rst_valid", o_valid, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_wrap", o_wrap, 0);
`ifdef SS_ROM_ADDR_SEQ_ERR_EN
        check("rst_err", o_err, 0);
`endif
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        check("idle_after_rst", o_valid, 0);

        // Reset in the middle of a run at address 0x0005
        start_seq(16'h0000, 16'h00FF, 4'd1, 1'b0, 1'b0);
        gen(16'h0000, 16'h00FF, 4'd1, 1'b0, 5);
        drain(20, 0);
        check("mid_addr", o_rom_addr, 16'h0005);
        i_ready = 1'b0;
        i_rst = 1'b1;
        #1;
        check("arst_addr", o_rom_addr, 0);
        check("arst_valid", o_valid, 0);
        check("arst_busy", o_busy, 0);
        check("arst_done", o_done, 0);
        check("arst_wrap", o_wrap, 0);
        #2;
        i_rst = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check("post_rst_valid", o_valid, 0);
        check("post_rst_busy", o_busy, 0);

        // One-shot 0x10..0x13, step 1
        start_seq(16'h0010, 16'h0013, 4'd1, 1'b0, 1'b1);
        gen(16'h0010, 16'h0013, 4'd1, 1'b0, 10);
        drain(30, 0);
        check("os_valid", o_valid, 0);
        check("os_busy", o_busy, 0);
        check("os_hold", o_rom_addr, model_next);
        @(posedge i_clk); #1;
        check("os_done_once", o_done, 0);

        // Wrap mode 0x00..0x0A, step 4, then stop
        start_seq(16'h0000, 16'h000A, 4'd4, 1'b1, 1'b1);
        gen(16'h0000, 16'h000A, 4'd4, 1'b1, 7);
        drain(30, 0);
        stop_seq();
        check("stop_valid", o_valid, 0);
        check("stop_busy", o_busy, 0);
        check("stop_hold", o_rom_addr, model_next);
        check("stop_no_wrap", o_wrap, 0);

        // Top of the address map: carry must end the run instead of wrapping to 0x0001
        start_seq(16'hFFFE, 16'hFFFF, 4'd3, 1'b0, 1'b1);
        gen(16'hFFFE, 16'hFFFF, 4'd3, 1'b0, 5);
        drain(20, 0);
        check("top_valid", o_valid, 0);
        check("top_hold", o_rom_addr, 16'hFFFE);

        // step 0 behaves as 1, ready toggled 1,0,0,1
        start_seq(16'h0030, 16'h0040, 4'd0, 1'b0, 1'b0);
        gen(16'h0030, 16'h0040, 4'd0, 1'b0, 4);
        drain(40, 1);
        check("s0_addr", o_rom_addr, model_next);
        // Restart while running: new base, no done pulse
        start_seq(16'h0050, 16'h0052, 4'd2, 1'b0, 1'b1);
        gen(16'h0050, 16'h0052, 4'd2, 1'b0, 5);
        drain(20, 0);
        check("rs_valid", o_valid, 0);

        // Start and stop together resolve to IDLE
        i_stop = 1'b1;
        start_seq(16'h0060, 16'h0070, 4'd1, 1'b0, 1'b1);
        i_stop = 1'b0;
        check("ss_valid", o_valid, 0);
        check("ss_busy", o_busy, 0);

        // base > last
`ifdef SS_ROM_ADDR_SEQ_ERR_EN
        start_seq(16'h0020, 16'h0010, 4'd1, 1'b0, 1'b1);
        check("err_set", o_err, 1);
        check("err_valid", o_valid, 0);
        check("err_busy", o_busy, 0);
        @(posedge i_clk); #1;
        check("err_sticky", o_err, 1);
        start_seq(16'h0020, 16'h0021, 4'd1, 1'b0, 1'b1);
        check("err_clear", o_err, 0);
        gen(16'h0020, 16'h0021, 4'd1, 1'b0, 5);
        drain(20, 0);
        check("err_os_valid", o_valid, 0);
`else
        start_seq(16'h0020, 16'h0010, 4'd1, 1'b0, 1'b1);
        gen(16'h0020, 16'h0010, 4'd1, 1'b0, 5);
        drain(20, 0);
        check("inv_os_valid", o_valid, 0);
        start_seq(16'h0020, 16'h0010, 4'd1, 1'b1, 1'b1);
        gen(16'h0020, 16'h0010, 4'd1, 1'b1, 3);
        drain(20, 0);
        stop_seq();
        check("inv_wr_hold", o_rom_addr, model_next);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
